fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Single-issue instruction fetch stage. It requests one word from
//   instruction memory, holds it for the decoder until it is consumed, then
//   advances the PC sequentially or to a taken-branch target. A memory
//   timeout or a misaligned branch target stops the unit in HALT until reset.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   TIMEOUT   FETCH cycles without imemAck before fetchErr / HALT
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   imemReq         read request (high only in FETCH)
//   imemAddr        read address, always equal to pc
//   imemAck         read data valid on imemRdata this cycle
//   imemRdata       instruction word from memory
//   instr           held instruction for the decoder
//   instrValid      instr/pc valid (high only in VALID)
//   instrReady      decoder consumes instr this cycle
//   pcSrc, immExt   taken-branch flag and sign-extended offset of the
//                   instruction being consumed
//   pc, pcPlus4     current PC and pc + 4 (wrapping)
//   retireCount     number of consumed instructions (wrapping)
//   fetchErr        sticky memory-timeout flag
//   misalign        sticky misaligned-branch-target flag
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        pcSrc,
  input  logic [31:0] immExt,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] retireCount,
  output logic        fetchErr,
  output logic        misalign
);

  // Counter is at least 8 bits and wide enough to hold TIMEOUT.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_instr;
  logic [31:0]     r_retire;
  logic [CW-1:0]   r_to_cnt;
  logic            r_imem_req;
  logic            r_instr_valid;
  logic            r_fetch_err;
  logic            r_misalign;

  logic [31:0]     w_pc_plus4;
  logic [31:0]     w_target;
  logic [CW-1:0]   w_to_inc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = r_pc + immExt;
  assign w_to_inc   = r_to_cnt + CW'(1);

  // imemReq and instrValid are kept as their own flops, updated together
  // with the state, so they never glitch on a state-decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_retire      <= 32'h0;
      r_to_cnt      <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end

        FETCH: begin
          if (imemAck) begin
            r_instr       <= imemRdata;
            r_to_cnt      <= '0;
            r_state       <= VALID;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end else begin
            r_to_cnt <= w_to_inc;
            if (w_to_inc >= TO_LIMIT) begin
              r_fetch_err <= 1'b1;
              r_state     <= HALT;
              r_imem_req  <= 1'b0;
            end
          end
        end

        VALID: begin
          if (instrReady) begin
            r_retire      <= r_retire + 32'd1;
            r_instr_valid <= 1'b0;
            if (pcSrc && (w_target[1:0] != 2'b00)) begin
              // Misaligned target: the branch retires but the PC is frozen.
              r_misalign <= 1'b1;
              r_state    <= HALT;
            end else begin
              r_pc       <= pcSrc ? w_target : w_pc_plus4;
              r_state    <= FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end

        default: begin
          // HALT: everything holds until reset.
          r_state <= HALT;
        end
      endcase
    end
  end

  assign imemReq     = r_imem_req;
  assign imemAddr    = r_pc;
  assign instr       = r_instr;
  assign instrValid  = r_instr_valid;
  assign pc          = r_pc;
  assign pcPlus4     = w_pc_plus4;
  assign retireCount = r_retire;
  assign fetchErr    = r_fetch_err;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed, table-driven bench for fetch_unit. Each table row is one
//   fetch/consume transaction; hand-written sequences cover misalign, reset
//   during FETCH, fetch timeout and a RESET_PC near the top of memory.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic        pcSrc;
  logic [31:0] immExt;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] retireCount;
  logic        fetchErr;
  logic        misalign;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemRdata(imemRdata),
    .instr(instr), .instrValid(instrValid), .instrReady(instrReady),
    .pcSrc(pcSrc), .immExt(immExt),
    .pc(pc), .pcPlus4(pcPlus4), .retireCount(retireCount),
    .fetchErr(fetchErr), .misalign(misalign)
  );

  // second instance: RESET_PC at the top of the address space
  logic        rst2_n;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic        valid2;
  logic        ready2;
  logic        src2;
  logic [31:0] imm2;
  logic [31:0] pc2;
  logic [31:0] pcp4_2;
  logic [31:0] retire2;
  logic        err2;
  logic        mis2;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imemReq(req2), .imemAddr(addr2),
    .imemAck(ack2), .imemRdata(rdata2),
    .instr(instr2), .instrValid(valid2), .instrReady(ready2),
    .pcSrc(src2), .immExt(imm2),
    .pc(pc2), .pcPlus4(pcp4_2), .retireCount(retire2),
    .fetchErr(err2), .misalign(mis2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_main(input string tag);
    check({tag, " imemReq"},     32'(imemReq), 32'd0);
    check({tag, " instrValid"},  32'(instrValid), 32'd0);
    check({tag, " pc"},          pc, 32'h0);
    check({tag, " imemAddr"},    imemAddr, 32'h0);
    check({tag, " pcPlus4"},     pcPlus4, 32'h4);
    check({tag, " instr"},       instr, 32'h0);
    check({tag, " retireCount"}, retireCount, 32'h0);
    check({tag, " fetchErr"},    32'(fetchErr), 32'd0);
    check({tag, " misalign"},    32'(misalign), 32'd0);
  endtask

  typedef struct {
    int          delay;     // no-ack FETCH cycles before the ack
    int          hold;      // VALID cycles with instrReady=0
    logic [31:0] rdata;
    logic        src;
    logic [31:0] imm;
    logic [31:0] exp_pc;    // pc of this instruction
    logic [31:0] exp_next;  // imemAddr after consume
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1, 0, 32'h0050_0093, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{0, 0, 32'h1111_1111, 1'b1, 32'h0000_000C, 32'h0000_0004, 32'h0000_0010};
    vecs[2] = '{2, 0, 32'h2222_2222, 1'b1, 32'hFFFF_FFF8, 32'h0000_0010, 32'h0000_0008};
    vecs[3] = '{0, 5, 32'h3333_3333, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C};
    vecs[4] = '{3, 0, 32'h4444_4444, 1'b1, 32'hFFFF_FFF0, 32'h0000_000C, 32'hFFFF_FFFC};
    vecs[5] = '{0, 2, 32'h5555_5555, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[6] = '{1, 0, 32'h6666_6666, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0100};

    rst_n = 1'b0; imemAck = 1'b0; imemRdata = 32'h0;
    instrReady = 1'b0; pcSrc = 1'b0; immExt = 32'h0;
    rst2_n = 1'b0; ack2 = 1'b0; rdata2 = 32'h0; ready2 = 1'b0; src2 = 1'b0; imm2 = 32'h0;

    step(); step();
    check_reset_main("reset");

    // release; IDLE lasts one cycle
    rst_n = 1'b1;
    check("idle imemReq", 32'(imemReq), 32'd0);
    step();
    check("first fetch imemReq", 32'(imemReq), 32'd1);

    // ---------------- table-driven transactions ----------------
    for (int v = 0; v < 7; v++) begin
      for (int d = 0; d < vecs[v].delay; d++) begin
        check($sformatf("v%0d wait imemReq", v), 32'(imemReq), 32'd1);
        check($sformatf("v%0d wait instrValid", v), 32'(instrValid), 32'd0);
        step();
      end
      check($sformatf("v%0d fetch imemAddr", v), imemAddr, vecs[v].exp_pc);
      imemAck = 1'b1; imemRdata = vecs[v].rdata;
      step();
      imemAck = 1'b0; imemRdata = 32'h0;
      check($sformatf("v%0d instr", v), instr, vecs[v].rdata);
      check($sformatf("v%0d instrValid", v), 32'(instrValid), 32'd1);
      check($sformatf("v%0d imemReq", v), 32'(imemReq), 32'd0);
      check($sformatf("v%0d pc", v), pc, vecs[v].exp_pc);
      check($sformatf("v%0d pcPlus4", v), pcPlus4, vecs[v].exp_pc + 32'd4);
      // stall: acks and branch inputs must be ignored
      for (int h = 0; h < vecs[v].hold; h++) begin
        imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF; pcSrc = 1'b1; immExt = 32'h0000_0002;
        step();
        check($sformatf("v%0d hold%0d instr", v, h), instr, vecs[v].rdata);
        check($sformatf("v%0d hold%0d pc", v, h), pc, vecs[v].exp_pc);
        check($sformatf("v%0d hold%0d instrValid", v, h), 32'(instrValid), 32'd1);
        check($sformatf("v%0d hold%0d imemReq", v, h), 32'(imemReq), 32'd0);
      end
      imemAck = 1'b0; imemRdata = 32'h0;
      instrReady = 1'b1; pcSrc = vecs[v].src; immExt = vecs[v].imm;
      step();
      instrReady = 1'b0; pcSrc = 1'b0; immExt = 32'h0;
      check($sformatf("v%0d next imemAddr", v), imemAddr, vecs[v].exp_next);
      check($sformatf("v%0d retireCount", v), retireCount, 32'(v + 1));
      check($sformatf("v%0d refetch imemReq", v), 32'(imemReq), 32'd1);
      check($sformatf("v%0d instrValid low", v), 32'(instrValid), 32'd0);
      $display("txn %0d: pc=%h instr=%h next=%h retire=%0d", v, pc, instr, imemAddr, retireCount);
    end

    // ---------------- misaligned branch target ----------------
    imemAck = 1'b1; imemRdata = 32'h7777_7777;
    step();
    imemAck = 1'b0;
    instrReady = 1'b1; pcSrc = 1'b1; immExt = 32'h0000_0006;
    step();
    instrReady = 1'b0; pcSrc = 1'b0; immExt = 32'h0;
    check("misalign flag", 32'(misalign), 32'd1);
    check("misalign pc held", pc, 32'h0000_0100);
    check("misalign retire", retireCount, 32'd8);
    check("misalign imemReq", 32'(imemReq), 32'd0);
    check("misalign instrValid", 32'(instrValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      imemAck = 1'b1; imemRdata = 32'hBAD0_BAD0; instrReady = 1'b1;
      step();
      check("halt imemReq", 32'(imemReq), 32'd0);
      check("halt instr", instr, 32'h7777_7777);
    end
    imemAck = 1'b0; instrReady = 1'b0;
    $display("txn misalign: pc=%h misalign=%0d retire=%0d", pc, misalign, retireCount);

    // asynchronous reset: visible before any clock edge
    rst_n = 1'b0;
    #2;
    check_reset_main("async reset");
    step();

    // ---------------- reset mid-FETCH abandons the request ----------------
    rst_n = 1'b1;
    step();                       // IDLE -> FETCH
    step();                       // one no-ack FETCH cycle
    check("midfetch imemReq", 32'(imemReq), 32'd1);
    rst_n = 1'b0; imemAck = 1'b1; imemRdata = 32'hAAAA_AAAA;
    step();
    check("midfetch reset instr", instr, 32'h0);
    check("midfetch reset instrValid", 32'(instrValid), 32'd0);
    rst_n = 1'b1;                 // ack still high during IDLE
    step();
    check("idle ack ignored instr", instr, 32'h0);
    check("idle ack ignored imemReq", 32'(imemReq), 32'd1);
    imemAck = 1'b0; imemRdata = 32'h0;
    $display("txn reset-mid-fetch: instr=%h imemReq=%0d", instr, imemReq);

    // ---------------- fetch timeout (TIMEOUT = 255) ----------------
    for (int i = 0; i < 254; i++) begin
      step();
    end
    check("timeout-1 fetchErr", 32'(fetchErr), 32'd0);
    check("timeout-1 imemReq", 32'(imemReq), 32'd1);
    step();
    check("timeout fetchErr", 32'(fetchErr), 32'd1);
    check("timeout imemReq", 32'(imemReq), 32'd0);
    imemAck = 1'b1; imemRdata = 32'hCCCC_CCCC;
    step(); step();
    check("timeout halt instr", instr, 32'h0);
    check("timeout halt instrValid", 32'(instrValid), 32'd0);
    check("timeout halt fetchErr", 32'(fetchErr), 32'd1);
    imemAck = 1'b0;
    $display("txn timeout: fetchErr=%0d imemReq=%0d", fetchErr, imemReq);
    rst_n = 1'b0;
    step();
    check_reset_main("post-timeout reset");
    rst_n = 1'b1;

    // ---------------- RESET_PC = FFFF_FFFC, sequential wrap ----------------
    check("dut2 reset pc", pc2, 32'hFFFF_FFFC);
    rst2_n = 1'b1;
    step();
    check("dut2 imemReq", 32'(req2), 32'd1);
    check("dut2 first addr", addr2, 32'hFFFF_FFFC);
    check("dut2 pcPlus4", pcp4_2, 32'h0000_0000);
    ack2 = 1'b1; rdata2 = 32'h0000_0013;
    step();
    ack2 = 1'b0;
    check("dut2 instr", instr2, 32'h0000_0013);
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    check("dut2 second addr", addr2, 32'h0000_0000);
    check("dut2 retire", retire2, 32'd1);
    check("dut2 err flags", {30'h0, err2, mis2}, 32'd0);
    $display("txn dut2 wrap: addr=%h retire=%0d", addr2, retire2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
